// File: rtl/pr_stage_elastic_pkg.sv
// rtl/pr_stage_elastic_pkg.sv - shared pipeline widths and ID/EX control field offsets
package pr_stage_elastic_pkg;

  localparam int IDEX_DATA_W  = 143;
  localparam int IDEX_CTRL_W  = 26;
  localparam int IFID_DATA_W  = 64;
  localparam int EXMEM_DATA_W = 105;
  localparam int EXMEM_CTRL_W = 14;
  localparam int MEMWB_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 3;

  // ID/EX control word layout, LSB first; wrappers pack and unpack with these.
  localparam int CTRL_ALU_LSB     = 0;
  localparam int CTRL_OP1_SEL_BIT = 6;
  localparam int CTRL_OP2_SEL_BIT = 7;
  localparam int CTRL_REG_WE_BIT  = 8;
  localparam int CTRL_MEM_WR_LSB  = 9;
  localparam int CTRL_MEM_RD_LSB  = 12;
  localparam int CTRL_BR_LSB      = 16;
  localparam int CTRL_CSR_LSB     = 20;
  localparam int CTRL_WB_LSB      = 24;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_SKID   = 1'b1
  } stage_mode_e;

endpackage

// File: rtl/pr_stage_elastic_slot.sv
// rtl/pr_stage_elastic_slot.sv - one valid+data+ctrl entry; ctrl is zeroed whenever the slot is empty
module pr_stage_elastic_slot
  import pr_stage_elastic_pkg::*;
#(
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CTRL_W = IDEX_CTRL_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Data is left in place on flush/unload; only the control word must go quiet.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (RESET) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = '0;
    end else if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    valid_q <= valid_d;
    data_q  <= data_d;
    ctrl_q  <= ctrl_d;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pr_stage_elastic.sv
// rtl/pr_stage_elastic.sv - elastic pipeline register with flush, stall counter and optional skid slot
module pr_stage_elastic
  import pr_stage_elastic_pkg::*;
#(
  parameter int DATA_W      = IDEX_DATA_W,
  parameter int CTRL_W      = IDEX_CTRL_W,
  parameter int SKID        = 0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FLUSH,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [DATA_W-1:0]      IN_DATA,
  input  logic [CTRL_W-1:0]      IN_CTRL,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [DATA_W-1:0]      OUT_DATA,
  output logic [CTRL_W-1:0]      OUT_CTRL,
  output logic [STALL_CNT_W-1:0] STALL_CNT
);

  localparam stage_mode_e MODE = (SKID != 0) ? MODE_SKID : MODE_SINGLE;

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] skid_data, main_load_data;
  logic [CTRL_W-1:0] skid_ctrl, main_load_ctrl;
  logic              in_xfer, out_xfer, main_load;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign IN_READY = (MODE == MODE_SKID) ? !skid_valid : (OUT_READY | !main_valid);
  assign in_xfer  = IN_VALID & IN_READY;
  assign out_xfer = main_valid & OUT_READY;

  // Main refills whenever it is (or is about to be) free; skid is older than IN, so it wins.
  assign main_load      = (!main_valid | out_xfer) & (in_xfer | skid_valid);
  assign main_load_data = skid_valid ? skid_data : IN_DATA;
  assign main_load_ctrl = skid_valid ? skid_ctrl : IN_CTRL;

  pr_stage_elastic_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush_i  (FLUSH),
    .load_i   (main_load),
    .unload_i (out_xfer),
    .data_i   (main_load_data),
    .ctrl_i   (main_load_ctrl),
    .valid_o  (main_valid),
    .data_o   (OUT_DATA),
    .ctrl_o   (OUT_CTRL)
  );

  if (MODE == MODE_SKID) begin : g_skid
    logic skid_load;
    assign skid_load = in_xfer & main_valid & !OUT_READY;

    pr_stage_elastic_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .CLK      (CLK),
      .RESET    (RESET),
      .flush_i  (FLUSH),
      .load_i   (skid_load),
      .unload_i (out_xfer),
      .data_i   (IN_DATA),
      .ctrl_i   (IN_CTRL),
      .valid_o  (skid_valid),
      .data_o   (skid_data),
      .ctrl_o   (skid_ctrl)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign skid_ctrl  = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (RESET)
      stall_cnt_d = '0;
    else if (main_valid && !OUT_READY && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    stall_cnt_q <= stall_cnt_d;
  end

  assign OUT_VALID = main_valid;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_pr_stage_elastic.sv
// tb/tb_pr_stage_elastic.sv - scoreboard bench driving a SKID=0 and a SKID=1 stage in parallel
module tb_pr_stage_elastic;

  typedef struct packed {
    logic [142:0] d;
    logic [25:0]  c;
  } ent_t;

  logic         CLK, RESET, FLUSH, IN_VALID, OUT_READY;
  logic [142:0] IN_DATA;
  logic [25:0]  IN_CTRL;
  logic         in_ready  [2];
  logic         out_valid [2];
  logic [142:0] out_data  [2];
  logic [25:0]  out_ctrl  [2];
  logic [15:0]  sc0;
  logic [3:0]   sc1;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t q [2][$];
  int   cnt_m [2] = '{0, 0};
  int   cnt_max [2] = '{65535, 15};

  pr_stage_elastic #(.DATA_W(143), .CTRL_W(26), .SKID(0), .STALL_CNT_W(16)) dut0 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready[0]), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
    .OUT_VALID(out_valid[0]), .OUT_READY(OUT_READY), .OUT_DATA(out_data[0]),
    .OUT_CTRL(out_ctrl[0]), .STALL_CNT(sc0)
  );

  pr_stage_elastic #(.DATA_W(143), .CTRL_W(26), .SKID(1), .STALL_CNT_W(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(in_ready[1]), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
    .OUT_VALID(out_valid[1]), .OUT_READY(OUT_READY), .OUT_DATA(out_data[1]),
    .OUT_CTRL(out_ctrl[1]), .STALL_CNT(sc1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: check both stages against a queue model, then advance the model for the next edge.
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      logic mrdy;
      ent_t e;
      logic [15:0] act_cnt;
      act_cnt = (k == 0) ? sc0 : {12'b0, sc1};
      mrdy = (k == 0) ? (OUT_READY || q[k].size() == 0) : (q[k].size() < 2);
      chk($sformatf("in_ready[%0d]", k), in_ready[k], mrdy);
      chk($sformatf("out_valid[%0d]", k), out_valid[k], q[k].size() != 0);
      if (q[k].size() == 0) chk($sformatf("bubble_ctrl[%0d]", k), out_ctrl[k], 0);
      chk($sformatf("stall_cnt[%0d]", k), act_cnt, cnt_m[k]);
      if (RESET) begin
        q[k].delete();
        cnt_m[k] = 0;
      end else begin
        if (q[k].size() != 0 && !OUT_READY && cnt_m[k] < cnt_max[k]) cnt_m[k]++;
        if (FLUSH) begin
          q[k].delete();
        end else begin
          if (q[k].size() != 0 && OUT_READY) begin
            e = q[k].pop_front();
            chk($sformatf("pop_data[%0d]", k), out_data[k], e.d);
            chk($sformatf("pop_ctrl[%0d]", k), out_ctrl[k], e.c);
          end
          if (IN_VALID && mrdy) q[k].push_back({IN_DATA, IN_CTRL});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [142:0] d, input logic [25:0] c);
    IN_VALID = v;
    IN_DATA  = d;
    IN_CTRL  = c;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [142:0] d, input logic [25:0] c);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_valid[%0d]", nm, k), out_valid[k], v);
      chk($sformatf("%s_data[%0d]", nm, k), out_data[k], d);
      chk($sformatf("%s_ctrl[%0d]", nm, k), out_ctrl[k], c);
    end
  endtask

  task automatic chk_cnt(input string nm, input int e0, input int e1);
    chk($sformatf("%s_cnt[0]", nm), sc0, e0);
    chk($sformatf("%s_cnt[1]", nm), sc1, e1);
  endtask

  task automatic chk_rdy(input string nm, input logic e);
    for (int k = 0; k < 2; k++) chk($sformatf("%s_rdy[%0d]", nm, k), in_ready[k], e);
  endtask

  initial begin
    logic [159:0] r;
    RESET = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b1;
    drive(1'b1, 143'h123, 26'h3FFFFFF);
    cyc(); cyc();
    chk_out("reset", 1'b0, 143'h0, 26'h0);
    chk_cnt("reset", 0, 0);
    chk_rdy("reset", 1'b1);
    RESET = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 143'(i), 26'(i + 1));
      cyc();
      chk_out("stream", 1'b1, 143'(i), 26'(i + 1));
    end

    drive(1'b1, 143'd8, 26'd9);
    OUT_READY = 1'b0;
    repeat (5) begin
      cyc();
      chk_out("stall", 1'b1, 143'd7, 26'd8);
    end
    chk_cnt("stall", 5, 5);
    chk_rdy("stall", 1'b0);
    OUT_READY = 1'b1;
    cyc(); chk_out("release", 1'b1, 143'd8, 26'd9);
    drive(1'b1, 143'd9, 26'd10); cyc(); chk_out("release", 1'b1, 143'd9, 26'd10);
    drive(1'b1, 143'd10, 26'd11); cyc(); chk_out("release", 1'b1, 143'd10, 26'd11);

    drive(1'b1, 143'd11, 26'd12);
    OUT_READY = 1'b0;
    cyc(); cyc();
    chk_out("preflush", 1'b1, 143'd10, 26'd11);
    drive(1'b1, 143'd12, 26'd13);
    FLUSH = 1'b1;
    cyc();
    chk_out("flush", 1'b0, 143'd10, 26'd0);
    chk_cnt("flush", 8, 8);
    chk_rdy("flush", 1'b1);
    FLUSH = 1'b0; OUT_READY = 1'b1;
    drive(1'b0, 143'd12, 26'd13);
    cyc();
    chk_out("postflush", 1'b0, 143'd10, 26'd0);
    chk_cnt("postflush", 8, 8);

    drive(1'b1, 143'hAAA, 26'h155); cyc(); chk_out("bubble_a", 1'b1, 143'hAAA, 26'h155);
    drive(1'b0, 143'h777, 26'h3FF); cyc(); chk_out("bubble", 1'b0, 143'hAAA, 26'h0);
    drive(1'b1, 143'hBBB, 26'h2AA); cyc(); chk_out("bubble_b", 1'b1, 143'hBBB, 26'h2AA);

    drive(1'b1, 143'hCCC, 26'h0F0);
    OUT_READY = 1'b0;
    repeat (20) cyc();
    chk_out("sat", 1'b1, 143'hBBB, 26'h2AA);
    chk_cnt("sat", 28, 15);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (4) cyc();
    for (int k = 0; k < 2; k++) chk($sformatf("drain_valid[%0d]", k), out_valid[k], 1'b0);
    chk_cnt("drain", 28, 15);

    for (int n = 0; n < 10000; n++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_DATA   = r[142:0];
      IN_CTRL   = r[159:134];
      OUT_READY = ($urandom_range(0, 2) != 0);
      FLUSH     = ($urandom_range(0, 63) == 0);
      RESET     = (n == 5000);
      cyc();
    end
    RESET = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
